// File: rtl/ram_sdp_bytewr.sv
// ----------------------------------------------------------------------------
// ram_sdp_bytewr
//
// Simple-dual-port synchronous RAM with one write port and one read port,
// both usable every cycle. Writes are byte-enabled. Reads are pipelined with a
// valid strobe and a latency of 1 or 2 cycles. After reset the array is cleared
// one word per cycle before the ports are opened. Out-of-range addresses are
// flagged with a one-cycle pulse.
//
// Optional feature macro: RAM_SDP_PARITY_EN
//   defined   : one even-parity bit is stored per byte (array par_q) and
//               checked on every read, reported on parity_err with rd_valid
//   undefined : no parity storage, parity_err is tied low
//
// Parameters
//   DATA_WIDTH      word width in bits (multiple of 8)
//   ADDR_BUS_WIDTH  address bus width
//   DEPTH           number of words (1 .. 2**ADDR_BUS_WIDTH)
//   RD_LATENCY      read latency in cycles (1 or 2)
//
// Ports
//   clk          clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   write_en     write request
//   wr_addr      write address
//   data_inbit   write data
//   byte_en      per-byte write enable (bit i covers data_inbit[8i+7:8i])
//   read_en      read request
//   rd_addr      read address
//   data_outbit  read data, qualified by rd_valid, holds when rd_valid=0
//   rd_valid     one-cycle strobe per accepted read
//   init_done    high once the clear sweep has completed
//   addr_err     one-cycle pulse after an out-of-range access
//   parity_err   parity mismatch on the returned word, qualified by rd_valid
// ----------------------------------------------------------------------------
module ram_sdp_bytewr #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_BUS_WIDTH = 8,
    parameter int DEPTH          = 2**ADDR_BUS_WIDTH,
    parameter int RD_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_en,
    input  logic [ADDR_BUS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     data_inbit,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    input  logic                      read_en,
    input  logic [ADDR_BUS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]     data_outbit,
    output logic                      rd_valid,
    output logic                      init_done,
    output logic                      addr_err,
    output logic                      parity_err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_BUS_WIDTH:0]   DEPTH_LIM = (ADDR_BUS_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_BUS_WIDTH-1:0] LAST_ADDR = ADDR_BUS_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_BUS_WIDTH-1:0] init_ptr_q;
    logic [DATA_WIDTH-1:0]     mem_q [0:DEPTH-1];

    logic                  is_ready;
    logic                  wr_in_range, rd_in_range;
    logic                  wr_accept, rd_accept;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_par_bad;

    logic                  s1_valid_q, s1_perr_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    assign is_ready    = (state_q == ST_READY);
    assign init_done   = is_ready;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
    assign wr_accept   = is_ready && write_en && wr_in_range;
    assign rd_accept   = is_ready && read_en && rd_in_range;
    assign same_addr   = wr_accept && (wr_addr == rd_addr);

    // State register and sweep pointer; reset restarts the clear sweep at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (!is_ready) begin
                init_ptr_q <= init_ptr_q + ADDR_BUS_WIDTH'(1);
            end
        end
    end

    // Leave INIT on the edge that clears the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_ptr_q == LAST_ADDR) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    // Data array: zero sweep while initialising, byte-merged writes afterwards.
    // No reset here so the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && !is_ready) begin
            mem_q[init_ptr_q] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_en[i]) mem_q[wr_addr][8*i +: 8] <= data_inbit[8*i +: 8];
            end
        end
    end

    // Write-first bypass: a same-address write in this cycle overrides the
    // stored bytes it enables, so the read sees the post-write word.
    always_comb begin
        rd_word = mem_q[rd_addr];
        if (same_addr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_en[i]) rd_word[8*i +: 8] = data_inbit[8*i +: 8];
            end
        end
    end

`ifdef RAM_SDP_PARITY_EN
    logic [NBYTES-1:0] par_q [0:DEPTH-1];
    logic [NBYTES-1:0] rd_par;

    // Parity bits follow the data array: zero during the sweep (matches an
    // all-zero word), recomputed only for the bytes actually written.
    always_ff @(posedge clk) begin
        if (rst_n && !is_ready) begin
            par_q[init_ptr_q] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_en[i]) par_q[wr_addr][i] <= ^data_inbit[8*i +: 8];
            end
        end
    end

    // Stored parity gets the same write-first bypass as the data before it is
    // compared against the parity of the returned bytes.
    always_comb begin
        rd_par     = par_q[rd_addr];
        rd_par_bad = 1'b0;
        if (same_addr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_en[i]) rd_par[i] = ^data_inbit[8*i +: 8];
            end
        end
        for (int i = 0; i < NBYTES; i++) begin
            if (rd_par[i] != ^rd_word[8*i +: 8]) rd_par_bad = 1'b1;
        end
    end
`else
    assign rd_par_bad = 1'b0;
`endif

    // First read stage: captures the array word. Data only moves on an
    // accepted read so the output holds its last value between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_perr_q  <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_accept;
            s1_perr_q  <= rd_accept && rd_par_bad;
            if (rd_accept) s1_data_q <= rd_word;
        end
    end

    // Optional second stage delays data, valid and parity together.
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid    <= 1'b0;
                    parity_err  <= 1'b0;
                    data_outbit <= '0;
                end else begin
                    rd_valid   <= s1_valid_q;
                    parity_err <= s1_perr_q;
                    if (s1_valid_q) data_outbit <= s1_data_q;
                end
            end
        end else begin : g_lat1
            assign rd_valid    = s1_valid_q;
            assign parity_err  = s1_perr_q;
            assign data_outbit = s1_data_q;
        end
    endgenerate

    // One pulse per cycle with any out-of-range request, even if both ports are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= is_ready && ((write_en && !wr_in_range) || (read_en && !rd_in_range));
        end
    end

endmodule

// File: tb/tb_ram_sdp_bytewr.sv
// ----------------------------------------------------------------------------
// tb_ram_sdp_bytewr
//
// Two instances share one set of inputs: instance 0 uses the defaults
// (DEPTH 256, latency 1), instance 1 uses DEPTH 200 and latency 2, so the
// same traffic also exercises out-of-range addresses and the output stage.
// A word-level reference model (array + queue of pending reads) predicts
// every output, and a few hand-computed values pin both DUT and model.
// ----------------------------------------------------------------------------
module tb_ram_sdp_bytewr;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = DW / 8;

`ifdef RAM_SDP_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          write_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] data_inbit;
    logic [BW-1:0] byte_en;
    logic          read_en;
    logic [AW-1:0] rd_addr;

    logic [1:0][DW-1:0] data_out;
    logic [1:0]         rd_valid;
    logic [1:0]         init_done;
    logic [1:0]         addr_err;
    logic [1:0]         parity_err;

    int vectors;
    int miscompares;
    bit checking;

    ram_sdp_bytewr dut (
        .clk(clk), .rst_n(rst_n),
        .write_en(write_en), .wr_addr(wr_addr), .data_inbit(data_inbit), .byte_en(byte_en),
        .read_en(read_en), .rd_addr(rd_addr),
        .data_outbit(data_out[0]), .rd_valid(rd_valid[0]), .init_done(init_done[0]),
        .addr_err(addr_err[0]), .parity_err(parity_err[0])
    );

    ram_sdp_bytewr #(.DEPTH(200), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .write_en(write_en), .wr_addr(wr_addr), .data_inbit(data_inbit), .byte_en(byte_en),
        .read_en(read_en), .rd_addr(rd_addr),
        .data_outbit(data_out[1]), .rd_valid(rd_valid[1]), .init_done(init_done[1]),
        .addr_err(addr_err[1]), .parity_err(parity_err[1])
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        perr;
    } rd_item_t;

    logic [31:0] mdl       [2][256];
    logic        par_bad   [2][256];
    rd_item_t    pend_q    [2][$];
    int          init_cnt  [2];
    int          cyc;
    logic        exp_valid [2];
    logic [31:0] exp_data  [2];
    logic        exp_aerr  [2];
    logic        exp_perr  [2];

    function automatic int depthOf(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic int latencyOf(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // One clock edge of the model for instance k: sweep first, then
    // write-before-read, then retire any read that is due this edge.
    task automatic modelEdge(input int k);
        int       dep;
        logic     w_ok, r_ok;
        rd_item_t item;
        dep         = depthOf(k);
        exp_aerr[k] = 1'b0;
        if (init_cnt[k] < dep) begin
            mdl[k][init_cnt[k]]     = 32'h0;
            par_bad[k][init_cnt[k]] = 1'b0;
            init_cnt[k]++;
        end else begin
            w_ok        = write_en && (int'(wr_addr) < dep);
            r_ok        = read_en && (int'(rd_addr) < dep);
            exp_aerr[k] = (write_en && !w_ok) || (read_en && !r_ok);
            if (w_ok) begin
                for (int i = 0; i < BW; i++) begin
                    if (byte_en[i]) begin
                        mdl[k][wr_addr][8*i +: 8] = data_inbit[8*i +: 8];
                        if (i == 0) par_bad[k][wr_addr] = 1'b0;
                    end
                end
            end
            if (r_ok) begin
                item.due  = cyc + latencyOf(k) - 1;
                item.data = mdl[k][rd_addr];
                item.perr = par_bad[k][rd_addr];
                pend_q[k].push_back(item);
            end
        end
        if (pend_q[k].size() > 0 && pend_q[k][0].due == cyc) begin
            item         = pend_q[k].pop_front();
            exp_valid[k] = 1'b1;
            exp_data[k]  = item.data;
            exp_perr[k]  = PAR_ON && item.perr;
        end else begin
            exp_valid[k] = 1'b0;
            exp_perr[k]  = 1'b0;
        end
    endtask

    // Model advances on every edge; reset empties it immediately.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                init_cnt[k]  = 0;
                pend_q[k].delete();
                exp_valid[k] = 1'b0;
                exp_data[k]  = 32'h0;
                exp_aerr[k]  = 1'b0;
                exp_perr[k]  = 1'b0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) modelEdge(k);
        end
    end

    // ------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Every output of both instances against the model, mid-cycle.
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("rd_valid[%0d]", k),   {31'h0, rd_valid[k]},   {31'h0, exp_valid[k]});
                checkOutput($sformatf("data_out[%0d]", k),   data_out[k],            exp_data[k]);
                checkOutput($sformatf("init_done[%0d]", k),  {31'h0, init_done[k]},  {31'h0, (init_cnt[k] >= depthOf(k))});
                checkOutput($sformatf("addr_err[%0d]", k),   {31'h0, addr_err[k]},   {31'h0, exp_aerr[k]});
                checkOutput($sformatf("parity_err[%0d]", k), {31'h0, parity_err[k]}, {31'h0, exp_perr[k]});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic applyStimulus(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                                 input logic [3:0] be, input logic re, input logic [7:0] ra);
        @(posedge clk);
        #1;
        write_en   = we;
        wr_addr    = wa;
        data_inbit = wd;
        byte_en    = be;
        read_en    = re;
        rd_addr    = ra;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00);
    endtask

    // Mostly a small window for frequent collisions, sometimes high addresses.
    function automatic logic [7:0] randAddr();
        if ($urandom_range(0, 7) == 0) return 8'($urandom_range(190, 255));
        return 8'($urandom_range(0, 15));
    endfunction

    task automatic applyRandom();
        applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom(), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), randAddr());
    endtask

    // Random traffic through the sweep; it must all be ignored while clearing.
    task automatic runSweep();
        for (int e = 1; e <= 256; e++) begin
            applyRandom();
            if (e == 199) checkOutput("init_b_199", {31'h0, init_done[1]}, 32'h0);
            if (e == 200) checkOutput("init_b_200", {31'h0, init_done[1]}, 32'h1);
            if (e == 255) checkOutput("init_a_255", {31'h0, init_done[0]}, 32'h0);
            if (e == 256) checkOutput("init_a_256", {31'h0, init_done[0]}, 32'h1);
        end
    endtask

    logic [31:0] pipe_words [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        checking    = 1'b0;
        cyc         = 0;
        rst_n       = 1'b1;
        write_en    = 1'b0;
        wr_addr     = '0;
        data_inbit  = '0;
        byte_en     = '0;
        read_en     = 1'b0;
        rd_addr     = '0;
        pipe_words  = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

        #2 rst_n = 1'b0;
        #1 checking = 1'b1;
        checkOutput("reset_valid", {31'h0, rd_valid[0]}, 32'h0);
        checkOutput("reset_data", data_out[1], 32'h0);
        repeat (3) applyIdle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        runSweep();

        // Freshly cleared word reads back as zero.
        applyStimulus(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h10);
        applyIdle();
        checkOutput("clr_valid_a", {31'h0, rd_valid[0]}, 32'h1);
        checkOutput("clr_data_a", data_out[0], 32'h0);
        applyIdle();
        checkOutput("clr_valid_b", {31'h0, rd_valid[1]}, 32'h1);

        // Byte enables: only bytes 0 and 2 of the second write land.
        applyStimulus(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h05, 32'h11223344, 4'b0101, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h05);
        applyIdle();
        checkOutput("bytes_a", data_out[0], 32'hDE22BE44);
        checkOutput("bytes_model", exp_data[0], 32'hDE22BE44);
        applyIdle();
        checkOutput("bytes_b", data_out[1], 32'hDE22BE44);

        // Same-cycle write and read of one address returns the new word.
        applyStimulus(1'b1, 8'h07, 32'hCAFEF00D, 4'hF, 1'b1, 8'h07);
        applyIdle();
        checkOutput("collide_a", data_out[0], 32'hCAFEF00D);
        checkOutput("collide_valid_a", {31'h0, rd_valid[0]}, 32'h1);
        applyIdle();
        checkOutput("collide_b", data_out[1], 32'hCAFEF00D);

        // Back-to-back reads through the two-stage instance.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i), pipe_words[i], 4'hF, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            if (i < 4) applyStimulus(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'(i));
            else applyIdle();
            if (i == 1 || i == 6) checkOutput($sformatf("pipe_gap_%0d", i), {31'h0, rd_valid[1]}, 32'h0);
            if (i >= 2 && i <= 5) begin
                checkOutput($sformatf("pipe_v_%0d", i), {31'h0, rd_valid[1]}, 32'h1);
                checkOutput($sformatf("pipe_d_%0d", i), data_out[1], pipe_words[i-2]);
            end
        end

        // Out of range for the 200-word instance only.
        applyStimulus(1'b1, 8'd250, 32'h5555AAAA, 4'hF, 1'b0, 8'h00);
        applyIdle();
        checkOutput("oor_wr_b", {31'h0, addr_err[1]}, 32'h1);
        checkOutput("oor_wr_a", {31'h0, addr_err[0]}, 32'h0);
        applyIdle();
        checkOutput("oor_wr_pulse", {31'h0, addr_err[1]}, 32'h0);
        applyStimulus(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'd250);
        applyIdle();
        checkOutput("oor_rd_b", {31'h0, addr_err[1]}, 32'h1);
        checkOutput("oor_rd_a_data", data_out[0], 32'h5555AAAA);
        applyStimulus(1'b1, 8'd220, 32'h1, 4'hF, 1'b1, 8'd230);
        applyIdle();
        checkOutput("oor_both", {31'h0, addr_err[1]}, 32'h1);
        applyIdle();
        checkOutput("oor_both_pulse", {31'h0, addr_err[1]}, 32'h0);

        // Free random traffic checked against the model.
        repeat (1500) applyRandom();

        // Reset with a read still inside the two-stage pipe.
        applyStimulus(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h02);
        applyIdle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_flight_valid", {31'h0, rd_valid[1]}, 32'h0);
        checkOutput("rst_init_a", {31'h0, init_done[0]}, 32'h0);
        checkOutput("rst_init_b", {31'h0, init_done[1]}, 32'h0);
        repeat (2) applyIdle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        runSweep();
        repeat (300) applyRandom();

        // Parity check on a word with one bit flipped behind the RAM's back.
        applyStimulus(1'b1, 8'h03, 32'h12345678, 4'hF, 1'b0, 8'h00);
        applyIdle();
`ifdef RAM_SDP_PARITY_EN
        dut.mem_q[3][0] = ~dut.mem_q[3][0];
        mdl[0][3][0]    = ~mdl[0][3][0];
        par_bad[0][3]   = 1'b1;
`endif
        applyStimulus(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h03);
        applyIdle();
        checkOutput("par_valid", {31'h0, rd_valid[0]}, 32'h1);
        checkOutput("par_err", {31'h0, parity_err[0]}, {31'h0, PAR_ON});
        checkOutput("par_data", data_out[0], PAR_ON ? 32'h12345679 : 32'h12345678);
        repeat (3) applyIdle();

        @(posedge clk);
        #1 checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
